// File: rtl/io_button_pkg.sv
// io_button_pkg: shared definitions for the io_button push-button peripheral.
//   Word addresses of the BTN_* registers on the dma_io bus and the bit
//   positions of the non-mask fields inside BTN_CTRL.
package io_button_pkg;

    localparam logic [13:0] IO_BTN_STATE = 14'h3F81;
    localparam logic [13:0] IO_BTN_EDGE  = 14'h3F82;
    localparam logic [13:0] IO_BTN_CTRL  = 14'h3F83;
    localparam logic [13:0] IO_BTN_FALL  = 14'h3F84;

    localparam int unsigned INV_BIT      = 8;
    localparam int unsigned FALL_IRQ_BIT = 9;

endpackage

// File: rtl/io_button_debounce.sv
// btn_debounce: single-bit two-flop synchronizer followed by a stability
// counter. A new level is accepted only after it has been sampled for
// DEB_CYCLES consecutive clocks; any return to the current level restarts
// the count.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   pol    in  polarity-corrected raw pin (asynchronous)
//   stable out debounced level
module btn_debounce
    import io_button_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned DEB_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pol,
    output logic stable
);

    localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s0;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s0     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= pol;
            s0 <= s1;
            if (s0 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_button.sv
// io_button: memory-mapped push-button input peripheral on the dma_io bus.
//   Debounces NBTN raw pins, exposes the debounced level (BTN_STATE),
//   latches rising edges into W1C flags (BTN_EDGE) and raises a maskable
//   level interrupt. BTN_CTRL holds the irq mask [NBTN-1:0] and the
//   polarity-invert bit (bit 8). Read data is daisy-chained.
// Optional feature: define IO_BTN_FALL_EN to add falling-edge W1C flags
//   (BTN_FALL) and the fall interrupt enable (BTN_CTRL bit 9).
// Ports:
//   clk             in  system clock
//   rst             in  asynchronous active-high reset
//   dma_io_we       in  bus write strobe
//   dma_io_wadr     in  bus write word address [15:2]
//   dma_io_wdata    in  bus write data
//   dma_io_radr     in  bus read word address [15:2]
//   dma_io_rdata_in in  read data from upstream slave
//   dma_io_rdata    out read data to downstream slave
//   btn_raw         in  asynchronous button pins
//   btn_irq         out level interrupt
module io_button
    import io_button_pkg::*;
#(
    parameter int unsigned NBTN       = 2,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned DEB_W      = 16,
    parameter logic        INV_RST    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dma_io_we,
    input  logic [15:2]     dma_io_wadr,
    input  logic [15:0]     dma_io_wdata,
    input  logic [15:2]     dma_io_radr,
    input  logic [15:0]     dma_io_rdata_in,
    output logic [15:0]     dma_io_rdata,
    input  logic [NBTN-1:0] btn_raw,
    output logic            btn_irq
);

    logic            inv;
    logic [NBTN-1:0] irq_mask;
    logic [NBTN-1:0] pol;
    logic [NBTN-1:0] stable;
    logic [NBTN-1:0] stable_d;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] edge_flag;
    logic [NBTN-1:0] w1c_edge;
    logic            wr_edge;
    logic            wr_ctrl;
    logic            unused_wdata;

    assign unused_wdata = ^dma_io_wdata;

    assign pol = btn_raw ^ {NBTN{inv}};

    for (genvar i = 0; i < NBTN; i++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .DEB_W     (DEB_W)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .pol   (pol[i]),
            .stable(stable[i])
        );
    end

    assign wr_edge  = dma_io_we && (dma_io_wadr == IO_BTN_EDGE);
    assign wr_ctrl  = dma_io_we && (dma_io_wadr == IO_BTN_CTRL);
    assign w1c_edge = wr_edge ? dma_io_wdata[NBTN-1:0] : '0;
    assign rise     = stable & ~stable_d;

    // A rise in the same cycle as a W1C clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d  <= '0;
            edge_flag <= '0;
            irq_mask  <= '0;
            inv       <= INV_RST;
        end else begin
            stable_d  <= stable;
            edge_flag <= rise | (edge_flag & ~w1c_edge);
            if (wr_ctrl) begin
                irq_mask <= dma_io_wdata[NBTN-1:0];
                inv      <= dma_io_wdata[INV_BIT];
            end
        end
    end

`ifdef IO_BTN_FALL_EN
    logic [NBTN-1:0] fall;
    logic [NBTN-1:0] fall_flag;
    logic [NBTN-1:0] w1c_fall;
    logic            fall_irq_en;
    logic            wr_fall;

    assign wr_fall  = dma_io_we && (dma_io_wadr == IO_BTN_FALL);
    assign w1c_fall = wr_fall ? dma_io_wdata[NBTN-1:0] : '0;
    assign fall     = ~stable & stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_flag   <= '0;
            fall_irq_en <= 1'b0;
        end else begin
            fall_flag <= fall | (fall_flag & ~w1c_fall);
            if (wr_ctrl) begin
                fall_irq_en <= dma_io_wdata[FALL_IRQ_BIT];
            end
        end
    end

    always_comb begin
        btn_irq = (|(edge_flag & irq_mask)) |
                  (fall_irq_en & (|(fall_flag & irq_mask)));
    end
`else
    always_comb begin
        btn_irq = |(edge_flag & irq_mask);
    end
`endif

    always_comb begin
        dma_io_rdata = dma_io_rdata_in;
        case (dma_io_radr)
            IO_BTN_STATE: begin
                dma_io_rdata           = '0;
                dma_io_rdata[NBTN-1:0] = stable;
            end
            IO_BTN_EDGE: begin
                dma_io_rdata           = '0;
                dma_io_rdata[NBTN-1:0] = edge_flag;
            end
            IO_BTN_CTRL: begin
                dma_io_rdata           = '0;
                dma_io_rdata[NBTN-1:0] = irq_mask;
                dma_io_rdata[INV_BIT]  = inv;
`ifdef IO_BTN_FALL_EN
                dma_io_rdata[FALL_IRQ_BIT] = fall_irq_en;
`endif
            end
`ifdef IO_BTN_FALL_EN
            IO_BTN_FALL: begin
                dma_io_rdata           = '0;
                dma_io_rdata[NBTN-1:0] = fall_flag;
            end
`endif
            default: ;
        endcase
    end

endmodule
